// File: rtl/wasm_bulk_mem_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wasm_pkg / wasm_bulk_mem_engine                             |
// | Description : memory.fill / memory.copy engine, one byte per cycle,      |
// |               with full bounds check before the first access.           |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+

package wasm_pkg;
    localparam int unsigned PAGE_SIZE    = 65536;
    localparam int unsigned MEMORY_PAGES = 16;

    typedef enum logic [3:0] {
        MEM_LOAD_I8_U  = 4'd0,
        MEM_LOAD_I8_S  = 4'd1,
        MEM_LOAD_I32   = 4'd2,
        MEM_LOAD_I64   = 4'd3,
        MEM_STORE_I8   = 4'd8,
        MEM_STORE_I32  = 4'd9,
        MEM_STORE_I64  = 4'd10
    } mem_op_t;

    typedef enum logic [2:0] {
        TRAP_NONE          = 3'd0,
        TRAP_OUT_OF_BOUNDS = 3'd1,
        TRAP_UNREACHABLE   = 3'd2
    } trap_t;
endpackage

module wasm_bulk_mem_engine
    import wasm_pkg::*;
#(
    parameter int unsigned PAGE_BYTES = PAGE_SIZE,
    parameter int unsigned MAX_PAGES  = MEMORY_PAGES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [31:0] cmd_dst,
    input  logic [31:0] cmd_src,
    input  logic [7:0]  cmd_val,
    input  logic [31:0] cmd_len,
    input  logic [31:0] current_pages,
    output logic        mem_rd_en,
    output logic [31:0] mem_rd_addr,
    output mem_op_t     mem_rd_op,
    input  logic [63:0] mem_rd_data,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_addr,
    output mem_op_t     mem_wr_op,
    output logic [63:0] mem_wr_data,
    input  trap_t       mem_trap,
    output logic        resp_valid,
    output trap_t       resp_trap,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        op_q, op_d;
    logic        bwd_q, bwd_d;
    logic [31:0] dst_q, dst_d;
    logic [31:0] src_q, src_d;
    logic [7:0]  val_q, val_d;
    logic [31:0] len_q, len_d;
    logic [31:0] pages_q, pages_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dcur_q, dcur_d;
    logic [31:0] scur_q, scur_d;
    trap_t       trap_q, trap_d;

    logic [63:0] limit;
    logic [32:0] end_dst;
    logic [32:0] end_src;
    logic        oob;
    logic        unused_rd_hi;

    // Widened arithmetic so that address + length overflow shows up as OOB.
    assign limit   = 64'(pages_q) * 64'(PAGE_BYTES);
    assign end_dst = {1'b0, dst_q} + {1'b0, len_q};
    assign end_src = {1'b0, src_q} + {1'b0, len_q};
    assign oob     = (64'(end_dst) > limit) || (op_q && (64'(end_src) > limit));

    assign mem_rd_op    = MEM_LOAD_I8_U;
    assign mem_wr_op    = MEM_STORE_I8;
    assign unused_rd_hi = ^mem_rd_data[63:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            bwd_q   <= 1'b0;
            dst_q   <= '0;
            src_q   <= '0;
            val_q   <= '0;
            len_q   <= '0;
            pages_q <= '0;
            rem_q   <= '0;
            dcur_q  <= '0;
            scur_q  <= '0;
            trap_q  <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            bwd_q   <= bwd_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            val_q   <= val_d;
            len_q   <= len_d;
            pages_q <= pages_d;
            rem_q   <= rem_d;
            dcur_q  <= dcur_d;
            scur_q  <= scur_d;
            trap_q  <= trap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        bwd_d       = bwd_q;
        dst_d       = dst_q;
        src_d       = src_q;
        val_d       = val_q;
        len_d       = len_q;
        pages_d     = pages_q;
        rem_d       = rem_q;
        dcur_d      = dcur_q;
        scur_d      = scur_q;
        trap_d      = trap_q;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        resp_valid  = 1'b0;
        resp_trap   = TRAP_NONE;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    dst_d   = cmd_dst;
                    src_d   = cmd_src;
                    val_d   = cmd_val;
                    len_d   = cmd_len;
                    pages_d = (current_pages > 32'(MAX_PAGES)) ? 32'(MAX_PAGES)
                                                               : current_pages;
                    state_d = CHECK;
                end
            end

            CHECK: begin
                rem_d = len_q;
                // Backward walk only when the destination lies above the source,
                // so overlapping copies read bytes before they are overwritten.
                bwd_d = op_q && (dst_q > src_q);
                if (op_q && (dst_q > src_q)) begin
                    dcur_d = dst_q + len_q - 32'd1;
                    scur_d = src_q + len_q - 32'd1;
                end else begin
                    dcur_d = dst_q;
                    scur_d = src_q;
                end
                if (oob) begin
                    trap_d  = TRAP_OUT_OF_BOUNDS;
                    state_d = RESP;
                end else if (len_q == 32'd0) begin
                    trap_d  = TRAP_NONE;
                    state_d = RESP;
                end else begin
                    trap_d  = TRAP_NONE;
                    state_d = RUN;
                end
            end

            RUN: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = dcur_q;
                if (op_q) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = scur_q;
                    mem_wr_data = {56'd0, mem_rd_data[7:0]};
                end else begin
                    mem_wr_data = {56'd0, val_q};
                end
                rem_d  = rem_q - 32'd1;
                dcur_d = bwd_q ? dcur_q - 32'd1 : dcur_q + 32'd1;
                scur_d = bwd_q ? scur_q - 32'd1 : scur_q + 32'd1;
                if (mem_trap != TRAP_NONE) begin
                    trap_d  = mem_trap;
                    state_d = RESP;
                end else if (rem_q == 32'd1) begin
                    trap_d  = TRAP_NONE;
                    state_d = RESP;
                end
            end

            RESP: begin
                resp_valid = 1'b1;
                resp_trap  = trap_q;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
